// File: rtl/rx_pkt_checker.sv
// Link self-check for the LVDS receive path: validates framing, checksum and per-channel
// payload continuity of each strobed 24-bit word, and keeps statistics plus a link watchdog.
module rx_pkt_checker #(
  parameter logic [3:0] SYNC        = 4'hA,
  parameter int         DATA_W      = 8,
  parameter int         CNT_W       = 16,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_ena,
  input  logic [23:0]       rx_data,
  input  logic              clr_stats,
  output logic              pkt_vld,
  output logic [1:0]        pkt_ch,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_err,
  output logic [2:0]        err_code,
  output logic [CNT_W-1:0]  good_cnt_1,
  output logic [CNT_W-1:0]  good_cnt_2,
  output logic [CNT_W-1:0]  good_cnt_3,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              link_timeout
);

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [1:0] ST_WAIT    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam logic [2:0] E_NONE = 3'd0;
  localparam logic [2:0] E_SYNC = 3'd1;
  localparam logic [2:0] E_CH   = 3'd2;
  localparam logic [2:0] E_SUM  = 3'd3;
  localparam logic [2:0] E_SEQ  = 3'd4;

  logic [1:0]              state_q, state_d;
  logic [WD_W-1:0]         wd_q, wd_d;
  logic                    to_q, to_d;
  logic [3:0][DATA_W-1:0]  exp_q, exp_d;
  logic [3:0][CNT_W-1:0]   good_q, good_d;
  logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
  logic                    vld_q, vld_d;
  logic                    perr_q, perr_d;
  logic [2:0]              code_q, code_d;
  logic [1:0]              ch_q, ch_d;
  logic [DATA_W-1:0]       data_q, data_d;

  logic [3:0]        f_sync;
  logic [1:0]        f_ch;
  logic [DATA_W-1:0] f_pay;
  logic [DATA_W-1:0] f_sum;
  logic              unused_rsvd;

  assign f_sync      = rx_data[23:20];
  assign f_ch        = rx_data[19:18];
  assign f_pay       = rx_data[15:8];
  assign f_sum       = rx_data[7:0];
  assign unused_rsvd = ^rx_data[17:16];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    to_d      = to_q;
    exp_d     = exp_q;
    good_d    = good_q;
    err_cnt_d = err_cnt_q;
    vld_d     = 1'b0;
    perr_d    = 1'b0;
    code_d    = code_q;
    ch_d      = ch_q;
    data_d    = data_q;

    if (clr_stats) begin
      state_d   = ST_WAIT;
      wd_d      = '0;
      to_d      = 1'b0;
      exp_d     = '0;
      good_d    = '0;
      err_cnt_d = '0;
      code_d    = E_NONE;
    end else begin
      // Watchdog only runs once the link has been seen alive.
      if (state_q == ST_RUN) begin
        if (rx_ena) begin
          wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          wd_d    = '0;
          state_d = ST_TIMEOUT;
          to_d    = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      if (rx_ena) begin
        if (f_sync != SYNC) begin
          code_d = E_SYNC;
        end else if (f_ch == 2'd0) begin
          code_d = E_CH;
        end else if (f_sum != ~f_pay) begin
          code_d = E_SUM;
        end else begin
          vld_d         = 1'b1;
          ch_d          = f_ch;
          data_d        = f_pay;
          state_d       = ST_RUN;
          wd_d          = '0;
          // Resync expectation to the received payload so a gap costs exactly one error.
          exp_d[f_ch]   = f_pay + DATA_W'(1);
          if (f_pay == exp_q[f_ch]) begin
            code_d       = E_NONE;
            good_d[f_ch] = sat_inc(good_q[f_ch]);
          end else begin
            code_d = E_SEQ;
          end
        end
        if (code_d != E_NONE) begin
          perr_d    = 1'b1;
          err_cnt_d = sat_inc(err_cnt_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT;
      wd_q      <= '0;
      to_q      <= 1'b0;
      exp_q     <= '0;
      good_q    <= '0;
      err_cnt_q <= '0;
      vld_q     <= 1'b0;
      perr_q    <= 1'b0;
      code_q    <= E_NONE;
      ch_q      <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      to_q      <= to_d;
      exp_q     <= exp_d;
      good_q    <= good_d;
      err_cnt_q <= err_cnt_d;
      vld_q     <= vld_d;
      perr_q    <= perr_d;
      code_q    <= code_d;
      ch_q      <= ch_d;
      data_q    <= data_d;
    end
  end

  assign pkt_vld      = vld_q;
  assign pkt_err      = perr_q;
  assign err_code     = code_q;
  assign pkt_ch       = ch_q;
  assign pkt_data     = data_q;
  assign good_cnt_1   = good_q[1];
  assign good_cnt_2   = good_q[2];
  assign good_cnt_3   = good_q[3];
  assign err_cnt      = err_cnt_q;
  assign link_timeout = to_q;

endmodule

// File: tb/tb_rx_pkt_checker.sv
// Bench for rx_pkt_checker: a full-width instance and a 2-bit-counter instance share stimulus;
// a queue-based scoreboard fed by a frame-level reference model checks every output pulse.
module tb_rx_pkt_checker;

  localparam int TO_CYC = 4096;
  localparam int CW_A   = 16;
  localparam int CW_B   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_ena = 1'b0;
  logic        clr_stats = 1'b0;
  logic [23:0] rx_data = '0;

  logic            vld_a, err_a, lt_a, vld_b, err_b, lt_b;
  logic [1:0]      ch_a, ch_b;
  logic [7:0]      data_a, data_b;
  logic [2:0]      code_a, code_b;
  logic [CW_A-1:0] g1_a, g2_a, g3_a, ec_a;
  logic [CW_B-1:0] g1_b, g2_b, g3_b, ec_b;

  always #5 clk = ~clk;

  rx_pkt_checker #(.SYNC(4'hA), .DATA_W(8), .CNT_W(CW_A), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .rx_ena(rx_ena), .rx_data(rx_data), .clr_stats(clr_stats),
    .pkt_vld(vld_a), .pkt_ch(ch_a), .pkt_data(data_a), .pkt_err(err_a), .err_code(code_a),
    .good_cnt_1(g1_a), .good_cnt_2(g2_a), .good_cnt_3(g3_a), .err_cnt(ec_a),
    .link_timeout(lt_a));

  rx_pkt_checker #(.SYNC(4'hA), .DATA_W(8), .CNT_W(CW_B), .TIMEOUT_CYC(TO_CYC)) dut_sat (
    .clk(clk), .rst_n(rst_n), .rx_ena(rx_ena), .rx_data(rx_data), .clr_stats(clr_stats),
    .pkt_vld(vld_b), .pkt_ch(ch_b), .pkt_data(data_b), .pkt_err(err_b), .err_code(code_b),
    .good_cnt_1(g1_b), .good_cnt_2(g2_b), .good_cnt_3(g3_b), .err_cnt(ec_b),
    .link_timeout(lt_b));

  typedef struct {
    bit vld; bit err; int code; int ch; int data; int g1; int g2; int g3; int ec; bit lt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: frame-level view of the link
  int m_exp[4];
  int m_good[4];
  int m_errs, m_state, m_idle, m_code, m_ch, m_data;
  bit m_to, m_vld, m_err;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_exp[k]  = 0;
      m_good[k] = 0;
    end
    m_errs = 0; m_state = 0; m_idle = 0; m_code = 0; m_ch = 0; m_data = 0;
    m_to = 0; m_vld = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit ena, input logic [23:0] d, input bit clr);
    logic [7:0] p;
    int c;
    exp_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_vld = 0;
    m_err = 0;
    if (clr) begin
      for (int k = 0; k < 4; k++) begin
        m_exp[k]  = 0;
        m_good[k] = 0;
      end
      m_errs = 0; m_to = 0; m_code = 0; m_state = 0; m_idle = 0;
      return;
    end
    if (m_state == 1 && !ena) begin
      m_idle++;
      if (m_idle >= TO_CYC) begin
        m_state = 2;
        m_to    = 1;
        m_idle  = 0;
      end
    end
    if (!ena) return;
    m_idle = 0;
    p = d[15:8];
    c = int'(d[19:18]);
    if (d[23:20] != 4'hA) m_code = 1;
    else if (c == 0) m_code = 2;
    else if (d[7:0] != ~p) m_code = 3;
    else begin
      m_vld   = 1;
      m_ch    = c;
      m_data  = int'(p);
      m_state = 1;
      m_code  = (int'(p) == m_exp[c]) ? 0 : 4;
      if (m_code == 0) m_good[c]++;
      m_exp[c] = (int'(p) + 1) % 256;
    end
    if (m_code != 0) begin
      m_err = 1;
      m_errs++;
    end
    e.vld = m_vld; e.err = m_err; e.code = m_code; e.ch = m_ch; e.data = m_data;
    e.g1 = m_good[1]; e.g2 = m_good[2]; e.g3 = m_good[3]; e.ec = m_errs; e.lt = m_to;
    sbq.push_back(e);
  endtask

  task automatic step(input bit ena, input logic [23:0] d, input bit clr);
    rx_ena    = ena;
    rx_data   = d;
    clr_stats = clr;
    @(posedge clk);
    model_edge(ena, d, clr);
    #1;
    rx_ena    = 1'b0;
    clr_stats = 1'b0;
  endtask

  function automatic logic [23:0] frame(input logic [1:0] ch, input logic [7:0] p);
    return {4'hA, ch, 2'b00, p, ~p};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_vld"}, vld_a, m_vld);
    chk({tag, "_err"}, err_a, m_err);
    chk({tag, "_code"}, code_a, m_code);
    chk({tag, "_ch"}, ch_a, m_ch);
    chk({tag, "_data"}, data_a, m_data);
    chk({tag, "_g1"}, g1_a, sat(m_good[1], CW_A));
    chk({tag, "_g2"}, g2_a, sat(m_good[2], CW_A));
    chk({tag, "_g3"}, g3_a, sat(m_good[3], CW_A));
    chk({tag, "_ec"}, ec_a, sat(m_errs, CW_A));
    chk({tag, "_lt"}, lt_a, m_to);
    chk({tag, "_g3_sat"}, g3_b, sat(m_good[3], CW_B));
    chk({tag, "_ec_sat"}, ec_b, sat(m_errs, CW_B));
    chk({tag, "_lt_sat"}, lt_b, m_to);
  endtask

  // Monitor: every expected pulse was queued at the edge that produced it
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("sb_vld", vld_a, mon_e.vld);
      chk("sb_err", err_a, mon_e.err);
      chk("sb_code", code_a, mon_e.code);
      if (mon_e.vld) begin
        chk("sb_ch", ch_a, mon_e.ch);
        chk("sb_data", data_a, mon_e.data);
      end
      chk("sb_g1", g1_a, sat(mon_e.g1, CW_A));
      chk("sb_g2", g2_a, sat(mon_e.g2, CW_A));
      chk("sb_g3", g3_a, sat(mon_e.g3, CW_A));
      chk("sb_ec", ec_a, sat(mon_e.ec, CW_A));
      chk("sb_vld_sat", vld_b, mon_e.vld);
      chk("sb_code_sat", code_b, mon_e.code);
      chk("sb_g1_sat", g1_b, sat(mon_e.g1, CW_B));
      chk("sb_g2_sat", g2_b, sat(mon_e.g2, CW_B));
      chk("sb_g3_sat", g3_b, sat(mon_e.g3, CW_B));
      chk("sb_ec_sat", ec_b, sat(mon_e.ec, CW_B));
    end else if (vld_a || err_a || vld_b || err_b) begin
      chk("sb_unexpected_pulse", {vld_a, err_a, vld_b, err_b}, 0);
    end
  end

  initial begin
    logic [1:0] rch;
    logic [7:0] rp;
    logic [3:0] sn;
    int r;

    model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 1'b0);
    check_all("reset");
    rst_n = 1'b1;

    // Channel 1 in-sequence
    step(1'b1, 24'hA400FF, 1'b0);
    step(1'b1, 24'hA401FE, 1'b0);
    step(1'b1, 24'hA402FD, 1'b0);
    step(1'b0, 24'h0, 1'b0);
    chk("ch1_good3", g1_a, 3);
    chk("ch1_err0", ec_a, 0);

    // Framing errors in priority order, then continuity proves exp[] untouched
    step(1'b1, 24'hB400FF, 1'b0);
    chk("sync_code", code_a, 1);
    step(1'b1, 24'hA000FF, 1'b0);
    chk("chan_code", code_a, 2);
    step(1'b1, 24'hA100FF, 1'b0);
    chk("chan_rsvd_code", code_a, 2);
    step(1'b1, 24'hA40000, 1'b0);
    chk("sum_code", code_a, 3);
    step(1'b0, 24'h0, 1'b0);
    chk("sum_code_hold", code_a, 3);
    chk("frame_errs", ec_a, 4);
    step(1'b1, 24'hA503FC, 1'b0);
    chk("ch1_cont", g1_a, 4);

    // Channel 2 with a gap: one sequence error then resync
    step(1'b1, frame(2'd2, 8'd0), 1'b0);
    step(1'b1, frame(2'd2, 8'd1), 1'b0);
    step(1'b1, frame(2'd2, 8'd5), 1'b0);
    chk("seq_code", code_a, 4);
    step(1'b1, frame(2'd2, 8'd6), 1'b0);
    chk("ch2_good3", g2_a, 3);
    chk("seq_errs", ec_a, 5);

    // Channel 3 past the small instance's counter ceiling
    for (int i = 0; i < 5; i++) step(1'b1, frame(2'd3, 8'(i)), 1'b0);
    chk("ch3_good5", g3_a, 5);
    chk("ch3_sat", g3_b, 3);
    check_all("post_dir");

    // Watchdog boundary
    for (int i = 0; i < TO_CYC - 1; i++) step(1'b0, 24'h0, 1'b0);
    chk("wd_before", lt_a, 0);
    step(1'b0, 24'h0, 1'b0);
    chk("wd_fire", lt_a, 1);
    step(1'b1, frame(2'd1, 8'd4), 1'b0);
    step(1'b0, 24'h0, 1'b0);
    chk("wd_sticky", lt_a, 1);
    check_all("timeout");
    step(1'b0, 24'h0, 1'b1);
    chk("clr_lt", lt_a, 0);
    chk("clr_g1", g1_a, 0);
    chk("clr_code", code_a, 0);
    check_all("clr");

    // Clear beats a simultaneous frame
    step(1'b1, frame(2'd1, 8'd0), 1'b0);
    step(1'b1, frame(2'd1, 8'd1), 1'b1);
    chk("clr_ena_vld", vld_a, 0);
    chk("clr_ena_g1", g1_a, 0);
    step(1'b1, frame(2'd1, 8'd0), 1'b0);
    chk("clr_ena_resync", g1_a, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r   = int'($urandom_range(0, 99));
      rch = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) rch = 2'd3;
      rp  = ($urandom_range(0, 9) < 8) ? 8'(m_exp[rch]) : 8'($urandom_range(0, 255));
      if (r < 3) step(1'b1, frame(rch, rp), 1'b1);
      else if (r < 20) step(1'b0, 24'h0, 1'b0);
      else if (r < 26) begin
        sn = 4'($urandom_range(0, 15));
        if (sn == 4'hA) sn = 4'h5;
        step(1'b1, {sn, rch, 2'($urandom), rp, ~rp}, 1'b0);
      end else if (r < 31) step(1'b1, {4'hA, 2'b00, 2'($urandom), rp, ~rp}, 1'b0);
      else if (r < 37) step(1'b1, {4'hA, rch, 2'b00, rp, ~rp ^ 8'($urandom_range(1, 255))}, 1'b0);
      else step(1'b1, {4'hA, rch, 2'($urandom), rp, ~rp}, 1'b0);
      if (i % 100 == 99) check_all("rand");
    end

    // Asynchronous reset mid-stream
    step(1'b1, frame(2'd2, 8'(m_exp[2])), 1'b0);
    chk("pre_rst_vld", vld_a, 1);
    rst_n = 1'b0;
    #1;
    sbq.delete();
    model_reset();
    check_all("async_rst");
    step(1'b1, frame(2'd1, 8'd0), 1'b0);
    check_all("in_rst");
    rst_n = 1'b1;
    step(1'b1, frame(2'd1, 8'd0), 1'b0);
    step(1'b0, 24'h0, 1'b0);
    check_all("final");
    chk("final_g1", g1_a, 1);
    #2;
    chk("queue_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
